rv_test_monitor: RTL and testbench

- Synthesizable completion monitor for riscv-tests style programs on the RV32 core; replaces the fixed-cycle, end-of-run register peek in the bench.
- Snoops the register-file write port and the fetched instruction word, and keeps shadow copies of a7, a0 and gp.
- On a terminating ecall it decides pass or fail; otherwise it flags a timeout after a programmable cycle budget.
- Parametrised in counter width, budget, register indices and exit code, so the same block serves both the bench and an on-FPGA self-test.

---
 rtl/rv_test_monitor_if.sv | 34 +++
 rtl/rv_test_monitor.sv | 102 ++++++++++
 tb/tb_rv_test_monitor.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_test_monitor_if.sv
// Snoop bundle between the RV32 core/bench and the completion monitor.
// master drives the core-side taps, slave is the monitor itself.
interface rv_test_monitor_if #(
    parameter int CYCLE_W = 16
);
    logic               start;
    logic               instr_valid;
    logic [31:0]        instr;
    logic               reg_we;
    logic [4:0]         reg_waddr;
    logic [31:0]        reg_wdata;
    logic               busy;
    logic               done;
    logic               pass;
    logic               fail;
    logic               timeout;
    logic [CYCLE_W-1:0] cycles;
    logic [31:0]        fail_test;
    logic [31:0]        test_num;

    modport master (
        output start, instr_valid, instr,
        output reg_we, reg_waddr, reg_wdata,
        input  busy, done, pass, fail, timeout,
        input  cycles, fail_test, test_num
    );

    modport slave (
        input  start, instr_valid, instr,
        input  reg_we, reg_waddr, reg_wdata,
        output busy, done, pass, fail, timeout,
        output cycles, fail_test, test_num
    );
endinterface

// File: rtl/rv_test_monitor.sv
// riscv-tests completion monitor: shadows a7/a0/gp, decides pass/fail
// on the exit ecall, or flags a timeout after a cycle budget.
module rv_test_monitor #(
    parameter int          CYCLE_W    = 16,
    parameter int          MAX_CYCLES = 840,
    parameter int          EXIT_CODE  = 93,
    parameter int          A7_IDX     = 17,
    parameter int          A0_IDX     = 10,
    parameter int          GP_IDX     = 3,
    parameter logic [31:0] ECALL_WORD = 32'h00000073
) (
    input  logic                 clock,
    input  logic                 reset,
    rv_test_monitor_if.slave     mon
);
    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_PASS, S_FAIL, S_TIMEOUT
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        a7_q, a0_q, gp_q;
    logic [31:0]        fail_q;
    logic [CYCLE_W-1:0] cnt_q;

    logic        wr_hit;
    logic        a7_wr, a0_wr, gp_wr;
    logic [31:0] a7_eff, a0_eff;
    logic        term_hit;
    logic        at_limit;

    assign wr_hit = mon.reg_we && (mon.reg_waddr != 5'd0);
    assign a7_wr  = wr_hit && (mon.reg_waddr == 5'(A7_IDX));
    assign a0_wr  = wr_hit && (mon.reg_waddr == 5'(A0_IDX));
    assign gp_wr  = wr_hit && (mon.reg_waddr == 5'(GP_IDX));

    // Same-cycle writes are forwarded so an ecall right after li a0 works
    assign a7_eff = a7_wr ? mon.reg_wdata : a7_q;
    assign a0_eff = a0_wr ? mon.reg_wdata : a0_q;

    assign term_hit = mon.instr_valid
                   && (mon.instr == ECALL_WORD)
                   && (a7_eff == 32'(EXIT_CODE));
    assign at_limit = (cnt_q == CYCLE_W'(MAX_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (mon.start) begin
            state_d = S_RUN;
        end else if (state_q == S_RUN) begin
            if (term_hit)
                state_d = (a0_eff == 32'd0) ? S_PASS : S_FAIL;
            else if (at_limit)
                state_d = S_TIMEOUT;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a7_q   <= '0;
            a0_q   <= '0;
            gp_q   <= '0;
            fail_q <= '0;
            cnt_q  <= '0;
        end else if (mon.start) begin
            a7_q   <= '0;
            a0_q   <= '0;
            gp_q   <= '0;
            fail_q <= '0;
            cnt_q  <= '0;
        end else if (state_q == S_RUN) begin
            cnt_q <= cnt_q + 1'b1;
            if (a7_wr) a7_q <= mon.reg_wdata;
            if (a0_wr) a0_q <= mon.reg_wdata;
            if (gp_wr) gp_q <= mon.reg_wdata;
            if (term_hit && (a0_eff != 32'd0))
                fail_q <= a0_eff >> 1;
        end
    end

    always_comb begin
        mon.busy      = 1'b0;
        mon.pass      = 1'b0;
        mon.fail      = 1'b0;
        mon.timeout   = 1'b0;
        unique case (state_q)
            S_RUN:     mon.busy    = 1'b1;
            S_PASS:    mon.pass    = 1'b1;
            S_FAIL:    mon.fail    = 1'b1;
            S_TIMEOUT: mon.timeout = 1'b1;
            default:   ;
        endcase
        mon.done      = mon.pass | mon.fail | mon.timeout;
        mon.cycles    = cnt_q;
        mon.fail_test = fail_q;
        mon.test_num  = gp_q;
    end
endmodule

// File: tb/tb_rv_test_monitor.sv
// Randomised bench for rv_test_monitor against a register-array model
// of the riscv-tests exit protocol, plus directed corner cases.
module tb_rv_test_monitor;
    localparam int CW    = 16;
    localparam int MAXC  = 840;
    localparam int EXITC = 93;
    localparam logic [31:0] ECALL = 32'h00000073;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PASS = 2;
    localparam int M_FAIL = 3;
    localparam int M_TO   = 4;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    rv_test_monitor_if #(.CYCLE_W(CW)) mif ();

    rv_test_monitor #(
        .CYCLE_W    (CW),
        .MAX_CYCLES (MAXC),
        .EXIT_CODE  (EXITC),
        .A7_IDX     (17),
        .A0_IDX     (10),
        .GP_IDX     (3),
        .ECALL_WORD (ECALL)
    ) dut (
        .clock (clock),
        .reset (reset),
        .mon   (mif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // reference: full architectural register view since last start
    logic [31:0] m_regs [32];
    int          m_state;
    int          m_cycles;
    logic [31:0] m_fail_test;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_state     = M_IDLE;
        m_cycles    = 0;
        m_fail_test = '0;
    endtask

    task automatic model_edge();
        logic [31:0] nxt [32];
        int          prev;
        if (mif.start) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_state     = M_RUN;
            m_cycles    = 0;
            m_fail_test = '0;
        end else if (m_state == M_RUN) begin
            nxt = m_regs;
            if (mif.reg_we && mif.reg_waddr != 0)
                nxt[mif.reg_waddr] = mif.reg_wdata;
            prev = m_cycles;
            m_cycles = m_cycles + 1;
            if (mif.instr_valid && mif.instr == ECALL
                && nxt[17] == 32'(EXITC)) begin
                if (nxt[10] == 0) begin
                    m_state = M_PASS;
                end else begin
                    m_state     = M_FAIL;
                    m_fail_test = nxt[10] / 2;
                end
            end else if (prev == MAXC - 1) begin
                m_state = M_TO;
            end
            m_regs = nxt;
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".busy"},    32'(mif.busy),    32'(m_state == M_RUN));
        chk({tag, ".pass"},    32'(mif.pass),    32'(m_state == M_PASS));
        chk({tag, ".fail"},    32'(mif.fail),    32'(m_state == M_FAIL));
        chk({tag, ".timeout"}, 32'(mif.timeout), 32'(m_state == M_TO));
        chk({tag, ".done"},    32'(mif.done),    32'(m_state >= M_PASS));
        chk({tag, ".cycles"},  32'(mif.cycles),  32'(m_cycles));
        chk({tag, ".fail_test"}, mif.fail_test,  m_fail_test);
        chk({tag, ".test_num"},  mif.test_num,   m_regs[3]);
    endtask

    task automatic idle_in();
        mif.start       = 1'b0;
        mif.instr_valid = 1'b0;
        mif.instr       = 32'h00000013;
        mif.reg_we      = 1'b0;
        mif.reg_waddr   = '0;
        mif.reg_wdata   = '0;
    endtask

    // apply current inputs across one edge, then check and go idle
    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        compare_all(tag);
        idle_in();
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        mif.reg_we    = 1'b1;
        mif.reg_waddr = 5'(a);
        mif.reg_wdata = d;
    endtask

    task automatic ecall();
        mif.instr_valid = 1'b1;
        mif.instr       = ECALL;
    endtask

    task automatic do_start();
        mif.start = 1'b1;
        step("start");
    endtask

    task automatic rand_in();
        int sel;
        idle_in();
        mif.start       = ($urandom_range(0, 299) == 0);
        mif.instr_valid = $urandom_range(0, 1) == 1;
        mif.instr       = ($urandom_range(0, 3) == 0) ? ECALL : $urandom;
        mif.reg_we      = $urandom_range(0, 1) == 1;
        sel = $urandom_range(0, 4);
        case (sel)
            0: mif.reg_waddr = 5'd0;
            1: mif.reg_waddr = 5'd3;
            2: mif.reg_waddr = 5'd10;
            3: mif.reg_waddr = 5'd17;
            default: mif.reg_waddr = 5'($urandom);
        endcase
        if (mif.reg_waddr == 5'd17 && $urandom_range(0, 1) == 1)
            mif.reg_wdata = 32'(EXITC);
        else if (mif.reg_waddr == 5'd10 && $urandom_range(0, 1) == 1)
            mif.reg_wdata = '0;
        else
            mif.reg_wdata = $urandom;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_in();
        model_reset();
        reset = 1'b0;
        #12;
        compare_all("reset");
        reset = 1'b1;
        @(negedge clock);

        // 1: pass with ecall 10 edges after start
        do_start();
        wr(17, 93);  step("t1");
        wr(10, 0);   step("t1");
        wr(3, 5);    step("t1");
        for (int i = 0; i < 6; i++) step("t1");
        ecall();     step("t1");
        chk("t1_pass",   32'(mif.pass), 1);
        chk("t1_cycles", 32'(mif.cycles), 10);
        chk("t1_tnum",   mif.test_num, 5);
        chk("t1_ftest",  mif.fail_test, 0);

        // 2: fail path
        do_start();
        wr(17, 93); step("t2");
        wr(10, 7);  step("t2");
        ecall();    step("t2");
        chk("t2_fail",  32'(mif.fail), 1);
        chk("t2_ftest", mif.fail_test, 3);
        chk("t2_pass",  32'(mif.pass), 0);

        // 3: wrong exit code, then timeout
        do_start();
        wr(17, 64); step("t3");
        ecall();    step("t3");
        chk("t3_busy", 32'(mif.busy), 1);
        while (mif.busy && m_cycles < MAXC + 5) step("t3");
        chk("t3_to",     32'(mif.timeout), 1);
        chk("t3_cycles", 32'(mif.cycles), MAXC);

        // 4: same-edge forwarding of a0
        do_start();
        wr(17, 93); step("t4");
        wr(10, 0); ecall(); step("t4");
        chk("t4_pass", 32'(mif.pass), 1);
        do_start();
        wr(17, 93); step("t4b");
        wr(10, 9); ecall(); step("t4b");
        chk("t4_fail",  32'(mif.fail), 1);
        chk("t4_ftest", mif.fail_test, 4);

        // 5: writes outside RUN ignored; restart after PASS
        reset = 1'b0;
        #1;
        model_reset();
        reset = 1'b1;
        wr(0, 93);  step("t5");
        wr(17, 93); step("t5");
        wr(3, 77);  step("t5");
        do_start();
        wr(0, 93); ecall(); step("t5");
        chk("t5_shadow", 32'(mif.busy), 1);
        wr(17, 93); step("t5");
        ecall();    step("t5");
        chk("t5_pass", 32'(mif.pass), 1);
        wr(3, 55);  step("t5");
        chk("t5_frz", mif.test_num, 0);
        do_start();
        chk("t5_rbusy", 32'(mif.busy), 1);
        chk("t5_rcyc",  32'(mif.cycles), 0);
        chk("t5_rdone", 32'(mif.done), 0);

        // 6a: async reset between edges
        wr(17, 93); step("t6");
        step("t6");
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all("t6_arst");
        #1;
        reset = 1'b1;

        // 6b: ecall on the timeout edge wins
        do_start();
        wr(17, 93); step("t6b");
        while (m_cycles < MAXC - 1) step("t6b");
        ecall(); step("t6b");
        chk("t6_pass", 32'(mif.pass), 1);
        chk("t6_to",   32'(mif.timeout), 0);
        chk("t6_cyc",  32'(mif.cycles), MAXC);

        // random traffic with occasional restarts and resets
        for (int n = 0; n < 4000; n++) begin
            rand_in();
            if (n % 500 == 7) mif.start = 1'b1;
            if (n == 2345) begin
                @(negedge clock);
                reset = 1'b0;
                #1;
                model_reset();
                compare_all("rnd_arst");
                reset = 1'b1;
            end
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
